// File: rtl/enoc_network_interface_if.sv
// Core-side and router-side signal bundle of the endpoint network interface.
// The master modport is the NI itself; the slave modport is the core/router environment.
interface enoc_network_interface_if #(
    parameter int ADDR_W = 4,
    parameter int TS_W   = 16,
    parameter int DATA_W = 32
);
    localparam int PKT_W = 2 * ADDR_W + TS_W + DATA_W;

    logic [DATA_W-1:0] i_core_data;
    logic [ADDR_W-1:0] i_core_dest;
    logic              i_core_val;
    logic              o_core_en;
    logic [PKT_W-1:0]  o_net_data;
    logic              o_net_val;
    logic              i_net_en;
    logic [PKT_W-1:0]  i_net_data;
    logic              i_net_val;
    logic              o_net_en;
    logic [DATA_W-1:0] o_rx_data;
    logic [ADDR_W-1:0] o_rx_src;
    logic [TS_W-1:0]   o_rx_latency;
    logic              o_rx_val;
    logic              i_rx_en;
    logic [31:0]       o_tx_count;
    logic [31:0]       o_rx_count;
    logic              o_drop;
    logic              o_misroute;
    logic              o_proto_err;

    modport master (
        input  i_core_data, i_core_dest, i_core_val, i_net_en, i_net_data, i_net_val, i_rx_en,
        output o_core_en, o_net_data, o_net_val, o_net_en, o_rx_data, o_rx_src, o_rx_latency,
               o_rx_val, o_tx_count, o_rx_count, o_drop, o_misroute, o_proto_err
    );

    modport slave (
        output i_core_data, i_core_dest, i_core_val, i_net_en, i_net_data, i_net_val, i_rx_en,
        input  o_core_en, o_net_data, o_net_val, o_net_en, o_rx_data, o_rx_src, o_rx_latency,
               o_rx_val, o_tx_count, o_rx_count, o_drop, o_misroute, o_proto_err
    );
endinterface

// File: rtl/enoc_network_interface.sv
// Endpoint NI: packetises core words into a TX FIFO toward router port 0 and
// collects ejected packets with their network latency into an RX FIFO.
module enoc_network_interface #(
    parameter int NODES    = 16,
    parameter int LOC      = 0,
    parameter int ADDR_W   = 4,
    parameter int TS_W     = 16,
    parameter int DATA_W   = 32,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    enoc_network_interface_if.master   ni
);
    localparam int PKT_W = 2 * ADDR_W + TS_W + DATA_W;
    localparam int RXE_W = ADDR_W + TS_W + DATA_W;
    localparam int TXP_W = $clog2(TX_DEPTH);
    localparam int RXP_W = $clog2(RX_DEPTH);
    localparam int TXC_W = TXP_W + 1;
    localparam int RXC_W = RXP_W + 1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [TS_W-1:0]   ts_r;
    logic [PKT_W-1:0]  tx_mem_r [TX_DEPTH];
    logic [TXP_W-1:0]  tx_wr_r;
    logic [TXP_W-1:0]  tx_rd_r;
    logic [TXC_W-1:0]  tx_cnt_r;
    logic [RXE_W-1:0]  rx_mem_r [RX_DEPTH];
    logic [RXP_W-1:0]  rx_wr_r;
    logic [RXP_W-1:0]  rx_rd_r;
    logic [RXC_W-1:0]  rx_cnt_r;
    logic [31:0]       tx_count_r;
    logic [31:0]       rx_count_r;
    logic              drop_r;
    logic              misroute_r;
    logic              proto_err_r;

    logic              tx_full_s;
    logic              tx_empty_s;
    logic              core_xfer_s;
    logic              dest_ok_s;
    logic              tx_push_s;
    logic              tx_pop_s;
    logic [PKT_W-1:0]  tx_pkt_s;
    logic              rx_full_s;
    logic              rx_empty_s;
    logic              net_xfer_s;
    logic              rx_pop_s;
    logic [ADDR_W-1:0] pkt_dest_s;
    logic [ADDR_W-1:0] pkt_src_s;
    logic [TS_W-1:0]   pkt_ts_s;
    logic [DATA_W-1:0] pkt_data_s;
    logic [TS_W-1:0]   lat_s;

    // Handshake decode; enables depend on current occupancy only, so a full FIFO refuses a push even when popping
    always_comb begin
        tx_full_s   = (tx_cnt_r == TXC_W'(TX_DEPTH));
        tx_empty_s  = (tx_cnt_r == TXC_W'(0));
        rx_full_s   = (rx_cnt_r == RXC_W'(RX_DEPTH));
        rx_empty_s  = (rx_cnt_r == RXC_W'(0));
        core_xfer_s = ni.i_core_val && !tx_full_s;
        dest_ok_s   = (32'(ni.i_core_dest) < 32'(NODES));
        tx_push_s   = core_xfer_s && dest_ok_s;
        tx_pop_s    = !tx_empty_s && ni.i_net_en;
        tx_pkt_s    = {ni.i_core_dest, ADDR_W'(LOC), ts_r, ni.i_core_data};
        net_xfer_s  = ni.i_net_val && !rx_full_s;
        rx_pop_s    = !rx_empty_s && ni.i_rx_en;
        {pkt_dest_s, pkt_src_s, pkt_ts_s, pkt_data_s} = ni.i_net_data;
        lat_s       = ts_r - pkt_ts_s;
    end

    assign ni.o_core_en    = !tx_full_s;
    assign ni.o_net_val    = !tx_empty_s;
    assign ni.o_net_data   = tx_mem_r[tx_rd_r];
    assign ni.o_net_en     = !rx_full_s;
    assign ni.o_rx_val     = !rx_empty_s;
    assign {ni.o_rx_src, ni.o_rx_latency, ni.o_rx_data} = rx_mem_r[rx_rd_r];
    assign ni.o_tx_count   = tx_count_r;
    assign ni.o_rx_count   = rx_count_r;
    assign ni.o_drop       = drop_r;
    assign ni.o_misroute   = misroute_r;
    assign ni.o_proto_err  = proto_err_r;

    // Free-running injection timestamp, wraps naturally at 2^TS_W
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ts_r <= '0;
        end else begin
            ts_r <= ts_r + TS_W'(1);
        end
    end

    // TX FIFO: storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < TX_DEPTH; i++) begin
                tx_mem_r[i] <= '0;
            end
            tx_wr_r  <= '0;
            tx_rd_r  <= '0;
            tx_cnt_r <= '0;
        end else begin
            if (tx_push_s) begin
                tx_mem_r[tx_wr_r] <= tx_pkt_s;
                tx_wr_r           <= tx_wr_r + TXP_W'(1);
            end
            if (tx_pop_s) begin
                tx_rd_r <= tx_rd_r + TXP_W'(1);
            end
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_cnt_r <= tx_cnt_r + TXC_W'(1);
                2'b01:   tx_cnt_r <= tx_cnt_r - TXC_W'(1);
                default: tx_cnt_r <= tx_cnt_r;
            endcase
        end
    end

    // RX FIFO: stores {source, latency, payload} of each accepted packet
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < RX_DEPTH; i++) begin
                rx_mem_r[i] <= '0;
            end
            rx_wr_r  <= '0;
            rx_rd_r  <= '0;
            rx_cnt_r <= '0;
        end else begin
            if (net_xfer_s) begin
                rx_mem_r[rx_wr_r] <= {pkt_src_s, lat_s, pkt_data_s};
                rx_wr_r           <= rx_wr_r + RXP_W'(1);
            end
            if (rx_pop_s) begin
                rx_rd_r <= rx_rd_r + RXP_W'(1);
            end
            case ({net_xfer_s, rx_pop_s})
                2'b10:   rx_cnt_r <= rx_cnt_r + RXC_W'(1);
                2'b01:   rx_cnt_r <= rx_cnt_r - RXC_W'(1);
                default: rx_cnt_r <= rx_cnt_r;
            endcase
        end
    end

    // Saturating transfer counters, drop pulse and sticky error flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_count_r  <= 32'd0;
            rx_count_r  <= 32'd0;
            drop_r      <= 1'b0;
            misroute_r  <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            if (tx_pop_s) begin
                tx_count_r <= sat_inc(tx_count_r);
            end
            if (net_xfer_s) begin
                rx_count_r <= sat_inc(rx_count_r);
            end
            drop_r <= core_xfer_s && !dest_ok_s;
            if (net_xfer_s && (pkt_dest_s != ADDR_W'(LOC))) begin
                misroute_r <= 1'b1;
            end
            if (ni.i_net_val && rx_full_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_enoc_network_interface.sv
// Scoreboard bench for enoc_network_interface: directed stimulus queues expected
// packets; negedge monitors compare every TX and RX transfer in order.
module tb_enoc_network_interface;
    localparam int NODES  = 16;
    localparam int LOC    = 5;
    localparam int ADDR_W = 5;
    localparam int TS_W   = 16;
    localparam int DATA_W = 32;
    localparam int PKT_W  = 2 * ADDR_W + TS_W + DATA_W;
    localparam int RXE_W  = ADDR_W + TS_W + DATA_W;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [TS_W-1:0] tb_ts;
    int n_checks = 0;
    int n_pass = 0;
    int exp_tx_cnt = 0;
    logic [PKT_W-1:0] tx_exp_q[$];
    logic [RXE_W-1:0] rx_exp_q[$];

    enoc_network_interface_if #(.ADDR_W(ADDR_W), .TS_W(TS_W), .DATA_W(DATA_W)) ni ();

    enoc_network_interface #(
        .NODES(NODES), .LOC(LOC), .ADDR_W(ADDR_W), .TS_W(TS_W), .DATA_W(DATA_W),
        .TX_DEPTH(4), .RX_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ni(ni)
    );

    always #5 clk = ~clk;

    // Reference timestamp: value of the NI counter during the current cycle
    always @(posedge clk) tb_ts <= !reset_n ? 16'd0 : tb_ts + 16'd1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [4:0] dest, input logic [4:0] src, input logic [15:0] lat,
                            input logic [31:0] data, input bit store);
        logic [15:0] ts;
        ts = tb_ts - lat;
        ni.i_net_data = {dest, src, ts, data};
        ni.i_net_val  = 1'b1;
        if (store) rx_exp_q.push_back({src, lat, data});
        step();
        ni.i_net_val = 1'b0;
    endtask

    task automatic inject(input logic [4:0] dest, input logic [31:0] data, input bit store);
        ni.i_core_dest = dest;
        ni.i_core_data = data;
        ni.i_core_val  = 1'b1;
        if (store) tx_exp_q.push_back({dest, 5'(LOC), tb_ts, data});
        step();
        ni.i_core_val = 1'b0;
    endtask

    task automatic wait_tx_empty(input string name);
        int n;
        n = 0;
        while (tx_exp_q.size() != 0 && n < 50) begin step(); n++; end
        check(name, 64'(tx_exp_q.size()), 64'd0);
    endtask

    task automatic wait_rx_empty(input string name);
        int n;
        n = 0;
        while (rx_exp_q.size() != 0 && n < 50) begin step(); n++; end
        check(name, 64'(rx_exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        tx_exp_q.delete();
        rx_exp_q.delete();
        exp_tx_cnt = 0;
        reset_n = 1'b1;
    endtask

    // TX monitor: every router-side transfer must match the queue head
    initial forever begin
        @(negedge clk);
        if (reset_n && ni.o_net_val && ni.i_net_en) begin
            exp_tx_cnt++;
            if (tx_exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL tx_unexpected: got 0x%0h, expected no packet", ni.o_net_data);
            end else begin
                check("tx_pkt", 64'(ni.o_net_data), 64'(tx_exp_q.pop_front()));
            end
        end
    end

    // RX monitor: every core-side delivery must match the queue head
    initial forever begin
        @(negedge clk);
        if (reset_n && ni.o_rx_val && ni.i_rx_en) begin
            if (rx_exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rx_unexpected: got 0x%0h, expected no packet",
                         {ni.o_rx_src, ni.o_rx_latency, ni.o_rx_data});
            end else begin
                check("rx_pkt", 64'({ni.o_rx_src, ni.o_rx_latency, ni.o_rx_data}), 64'(rx_exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        ni.i_core_data = 32'd0;
        ni.i_core_dest = 5'd0;
        ni.i_core_val  = 1'b0;
        ni.i_net_en    = 1'b0;
        ni.i_net_data  = '0;
        ni.i_net_val   = 1'b0;
        ni.i_rx_en     = 1'b0;
        step();
        do_reset();

        // Reset state
        check("rst_flags", 64'({ni.o_net_val, ni.o_rx_val, ni.o_core_en, ni.o_net_en,
                                ni.o_drop, ni.o_misroute, ni.o_proto_err}), 64'b0011000);
        check("rst_counts", {ni.o_tx_count, ni.o_rx_count}, 64'd0);
        check("rst_net_data", 64'(ni.o_net_data), 64'd0);
        check("rst_rx_data", 64'({ni.o_rx_src, ni.o_rx_latency, ni.o_rx_data}), 64'd0);

        // Single injection at counter 10
        ni.i_net_en = 1'b1;
        while (tb_ts != 16'd10) step();
        ni.i_core_dest = 5'd3;
        ni.i_core_data = 32'hCAFE_F00D;
        ni.i_core_val  = 1'b1;
        tx_exp_q.push_back({5'd3, 5'd5, 16'd10, 32'hCAFE_F00D});
        step();
        ni.i_core_val = 1'b0;
        check("tx_val_latency", 64'(ni.o_net_val), 64'd1);
        step();
        check("tx_count_one", 64'(ni.o_tx_count), 64'd1);

        // Fill TX with router stalled, then drain in order
        ni.i_net_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("core_en_room", 64'(ni.o_core_en), 64'd1);
            inject(5'(k + 1), 32'h1000_0000 + 32'(k), 1'b1);
        end
        ni.i_core_dest = 5'd9;
        ni.i_core_data = 32'hDEAD_BEEF;
        ni.i_core_val  = 1'b1;
        check("core_en_full", 64'(ni.o_core_en), 64'd0);
        step();
        step();
        check("core_en_held", 64'(ni.o_core_en), 64'd0);
        ni.i_core_val = 1'b0;
        ni.i_net_en   = 1'b1;
        wait_tx_empty("tx_drain4");
        check("core_en_after", 64'(ni.o_core_en), 64'd1);
        check("tx_count_five", 64'(ni.o_tx_count), 64'(exp_tx_cnt));

        // Ejection with timestamp wrap
        do_reset();
        ni.i_net_en = 1'b1;
        while (tb_ts != 16'h0010) step();
        check("net_en_empty", 64'(ni.o_net_en), 64'd1);
        ni.i_net_data = {5'd5, 5'd2, 16'hFFF0, 32'h0000_1234};
        ni.i_net_val  = 1'b1;
        rx_exp_q.push_back({5'd2, 16'h0020, 32'h0000_1234});
        step();
        ni.i_net_val = 1'b0;
        check("rx_val_next", 64'(ni.o_rx_val), 64'd1);
        check("rx_count_one", 64'(ni.o_rx_count), 64'd1);
        check("no_misroute", 64'(ni.o_misroute), 64'd0);
        ni.i_rx_en = 1'b1;
        wait_rx_empty("rx_drain1");
        ni.i_rx_en = 1'b0;

        // RX full: extra packet refused, protocol error sticks
        for (int k = 0; k < 4; k++) send_pkt(5'd5, 5'(k), 16'(3 * k + 1), 32'hA000_0000 + 32'(k), 1'b1);
        check("net_en_full", 64'(ni.o_net_en), 64'd0);
        check("proto_before", 64'(ni.o_proto_err), 64'd0);
        send_pkt(5'd5, 5'd9, 16'd7, 32'hBAD0_0000, 1'b0);
        check("proto_set", 64'(ni.o_proto_err), 64'd1);
        check("rx_count_five", 64'(ni.o_rx_count), 64'd5);
        ni.i_rx_en = 1'b1;
        wait_rx_empty("rx_drain4");
        step();
        check("rx_empty_after", 64'(ni.o_rx_val), 64'd0);
        check("proto_sticky", 64'(ni.o_proto_err), 64'd1);

        // Misrouted packet is still delivered
        send_pkt(5'd7, 5'd3, 16'd2, 32'h7777_0007, 1'b1);
        check("misroute_set", 64'(ni.o_misroute), 64'd1);
        wait_rx_empty("rx_misroute");
        ni.i_rx_en = 1'b0;

        // Out-of-range destination is dropped
        inject(5'd2, 32'h2222_0002, 1'b1);
        wait_tx_empty("tx_before_drop");
        ni.i_core_dest = 5'd16;
        ni.i_core_data = 32'h1616_1616;
        ni.i_core_val  = 1'b1;
        check("drop_core_en", 64'(ni.o_core_en), 64'd1);
        step();
        ni.i_core_val = 1'b0;
        check("drop_pulse", 64'(ni.o_drop), 64'd1);
        step();
        check("drop_end", 64'(ni.o_drop), 64'd0);
        check("drop_no_pkt", 64'(ni.o_net_val), 64'd0);
        check("drop_tx_count", 64'(ni.o_tx_count), 64'd1);

        // Reset with two packets in each FIFO
        ni.i_net_en = 1'b0;
        inject(5'd1, 32'h0101_0101, 1'b1);
        inject(5'd4, 32'h0404_0404, 1'b1);
        send_pkt(5'd5, 5'd1, 16'd3, 32'h5151_5151, 1'b1);
        send_pkt(5'd5, 5'd6, 16'd4, 32'h5656_5656, 1'b1);
        check("pre_rst_state", 64'({ni.o_net_val, ni.o_rx_val, ni.o_misroute, ni.o_proto_err}), 64'b1111);
        reset_n = 1'b0;
        step();
        tx_exp_q.delete();
        rx_exp_q.delete();
        exp_tx_cnt = 0;
        check("mid_rst_flags", 64'({ni.o_net_val, ni.o_rx_val, ni.o_core_en, ni.o_net_en,
                                    ni.o_drop, ni.o_misroute, ni.o_proto_err}), 64'b0011000);
        check("mid_rst_counts", {ni.o_tx_count, ni.o_rx_count}, 64'd0);
        reset_n = 1'b1;
        ni.i_net_en = 1'b1;
        ni.i_rx_en  = 1'b1;
        step();
        step();
        check("post_rst_idle", 64'({ni.o_net_val, ni.o_rx_val}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
